// File: rtl/vga_ctrl_scheduler.sv
// vga_ctrl_scheduler: round-robin intake of display control words from up to
// three requesters into a small FIFO, committing exactly one queued word to
// Ctrl per frame at the start of vertical sync.
module vga_ctrl_scheduler #(
  parameter int                CTRL_W     = 25,
  parameter logic [CTRL_W-1:0] CTRL_RESET = '0,
  parameter int                DEPTH      = 4
) (
  input  logic              CLK_to_DAC,
  input  logic              RST_N,
  input  logic              VGA_VS,
  input  logic [2:0]        req_valid,
  input  logic [CTRL_W-1:0] req_data0,
  input  logic [CTRL_W-1:0] req_data1,
  input  logic [CTRL_W-1:0] req_data2,
  output logic [2:0]        req_ready,
  output logic [CTRL_W-1:0] Ctrl,
  output logic              commit_pulse,
  output logic [2:0]        pending
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT, GUARD} state_t;

  state_t            state, state_nxt;
  logic              vs_s1, vs_s2, vs_s3, vs_fall;
  logic [CTRL_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [2:0]        count;
  logic [1:0]        last;
  logic [1:0]        cand;
  logic [1:0]        grant_idx;
  logic              full, push, pop;
  logic [CTRL_W-1:0] push_data;

  assign vs_fall = vs_s3 & ~vs_s2;
  assign full    = (count == 3'(DEPTH));
  assign push    = |req_ready;
  assign pop     = (state == COMMIT);
  assign pending = count;

  // Round-robin grant: search starts one past the last transferred port.
  always_comb begin
    req_ready = '0;
    grant_idx = last;
    cand      = '0;
    if (!full) begin
      for (int unsigned k = 1; k <= 3; k++) begin
        cand = 2'((32'(last) + k) % 32'd3);
        if (req_valid[cand] && (req_ready == '0)) begin
          req_ready[cand] = 1'b1;
          grant_idx       = cand;
        end
      end
    end
  end

  // Select the data word of the granted port.
  always_comb begin
    case (grant_idx)
      2'd0:    push_data = req_data0;
      2'd1:    push_data = req_data1;
      default: push_data = req_data2;
    endcase
  end

  // Three-stage synchroniser / edge detector on the asynchronous VS input.
  always_ff @(posedge CLK_to_DAC or negedge RST_N) begin
    if (!RST_N) begin
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_s3 <= 1'b1;
    end else begin
      vs_s1 <= VGA_VS;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  // FIFO pointers, occupancy and last-granted port.
  always_ff @(posedge CLK_to_DAC or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      last  <= 2'd2;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        last <= grant_idx;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge CLK_to_DAC) begin
    if (push)
      mem[wptr] <= push_data;
  end

  // Scheduler state register.
  always_ff @(posedge CLK_to_DAC or negedge RST_N) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic. IDLE looks at the registered count, so a word pushed
  // once the VS fall is already detected waits for the following pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ARMED;
      ARMED:   if (vs_fall) state_nxt = COMMIT;
      COMMIT:  state_nxt = GUARD;
      GUARD:   if (vs_s2) state_nxt = (count != '0) ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered commit of the FIFO head to Ctrl with a one-cycle strobe.
  always_ff @(posedge CLK_to_DAC or negedge RST_N) begin
    if (!RST_N) begin
      Ctrl         <= CTRL_RESET;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= (state == COMMIT);
      if (state == COMMIT)
        Ctrl <= mem[rptr];
    end
  end

endmodule
